// File: rtl/eth_ip_hdr_gen_if.sv
// Request and header handshake bundle for the Ethernet/IPv4 header generator.
interface eth_ip_hdr_gen_if;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned PROTO_W = 8;
    localparam int unsigned IP_W    = 32;
    localparam int unsigned MAC_W   = 48;
    localparam int unsigned HDR_W   = 272;
    localparam int unsigned CNT_W   = 32;

    logic               i_req_valid;
    logic               o_req_ready;
    logic [LEN_W-1:0]   i_payload_len;
    logic [PROTO_W-1:0] i_protocol;
    logic [IP_W-1:0]    i_src_ip;
    logic [IP_W-1:0]    i_dest_ip;
    logic [MAC_W-1:0]   i_mac_src;
    logic [MAC_W-1:0]   i_mac_dest;
    logic               o_hdr_valid;
    logic               i_hdr_ready;
    logic [HDR_W-1:0]   o_hdr;
    logic               o_len_err;
    logic [CNT_W-1:0]   o_pkt_count;

    // Generator side
    modport slave (
        input  i_req_valid, i_payload_len, i_protocol, i_src_ip, i_dest_ip,
               i_mac_src, i_mac_dest, i_hdr_ready,
        output o_req_ready, o_hdr_valid, o_hdr, o_len_err, o_pkt_count
    );

    // Requester / consumer side
    modport master (
        output i_req_valid, i_payload_len, i_protocol, i_src_ip, i_dest_ip,
               i_mac_src, i_mac_dest, i_hdr_ready,
        input  o_req_ready, o_hdr_valid, o_hdr, o_len_err, o_pkt_count
    );
endinterface

// File: rtl/eth_ip_hdr_gen.sv
// Builds a 14-byte MAC header plus 20-byte IPv4 header with a multi-cycle
// checksum: SUM adds SUM_LANES header words per cycle, FOLD folds twice and
// inverts, OUT presents the header until the downstream accepts it.
module eth_ip_hdr_gen #(
    parameter int unsigned SUM_LANES    = 2,
    parameter int unsigned BYTE_REVERSE = 1,
    parameter int unsigned TTL          = 128
) (
    input  logic            i_clk,
    input  logic            i_reset,
    eth_ip_hdr_gen_if.slave bus
);
    localparam int unsigned N_WORDS = 10;
    localparam int unsigned N_CYC   = N_WORDS / SUM_LANES;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned ACC_W   = 20;
    localparam int unsigned FOLD_W  = 17;
    localparam int unsigned HDR_W   = 272;
    localparam int unsigned HDR_B   = HDR_W / 8;
    localparam int unsigned MAX_PAY = 65515;
    localparam int unsigned IP_OVH  = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUM,
        ST_FOLD,
        ST_OUT
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [15:0]        cks_q;
    logic [15:0]        pkt_len_q;
    logic               len_err_q;
    logic [7:0]         proto_q;
    logic [31:0]        src_q;
    logic [31:0]        dst_q;
    logic [47:0]        macs_q;
    logic [47:0]        macd_q;
    logic [15:0]        id_q;
    logic [15:0]        id_cur_q;
    logic               req_ready_q;
    logic               hdr_valid_q;
    logic [HDR_W-1:0]   hdr_q;
    logic               len_err_out_q;
    logic [31:0]        pkt_cnt_q;

    logic [15:0]        words [2**IDX_W];
    logic [ACC_W-1:0]   lane_sum;
    logic [ACC_W-1:0]   acc_d;
    logic [FOLD_W-1:0]  fold_t;
    logic [15:0]        fold_f;
    logic [15:0]        cks_d;
    logic               len_ok;
    logic [15:0]        pkt_len_d;
    logic [HDR_W-1:0]   hdr_wire;
    logic [HDR_W-1:0]   hdr_rev;
    logic [HDR_W-1:0]   hdr_d;

    // IPv4 header words in wire order; checksum slot is zero while summing
    always_comb begin
        words     = '{default: '0};
        words[0]  = 16'h4500;
        words[1]  = pkt_len_q;
        words[2]  = id_cur_q;
        words[3]  = 16'h4000;
        words[4]  = {8'(TTL), proto_q};
        words[5]  = 16'h0000;
        words[6]  = src_q[31:16];
        words[7]  = src_q[15:0];
        words[8]  = dst_q[31:16];
        words[9]  = dst_q[15:0];
    end

    // Add this cycle's group of SUM_LANES consecutive words to the accumulator
    always_comb begin
        lane_sum = '0;
        for (int unsigned k = 0; k < SUM_LANES; k++) begin
            lane_sum = lane_sum
                     + ACC_W'(words[IDX_W'(cnt_q * IDX_W'(SUM_LANES)) + IDX_W'(k)]);
        end
        acc_d = acc_q + lane_sum;
    end

    // Two end-around carry folds then invert; second fold cannot carry again
    always_comb begin
        fold_t = FOLD_W'(acc_q[19:16]) + FOLD_W'(acc_q[15:0]);
        fold_f = fold_t[15:0] + 16'(fold_t[16]);
        cks_d  = ~fold_f;
    end

    // Total length saturates to 0xFFFF when payload plus header cannot fit
    always_comb begin
        len_ok    = (bus.i_payload_len <= 16'(MAX_PAY));
        pkt_len_d = len_ok ? (bus.i_payload_len + 16'(IP_OVH)) : 16'hFFFF;
    end

    // Assemble MAC + IP header, first wire byte at the MSB end
    always_comb begin
        hdr_wire = {macd_q, macs_q, 16'h0800,
                    words[0], words[1], words[2], words[3], words[4],
                    cks_q,
                    words[6], words[7], words[8], words[9]};
        hdr_rev  = '0;
        for (int unsigned i = 0; i < HDR_B; i++) begin
            hdr_rev[8*i +: 8] = hdr_wire[HDR_W-8-8*i +: 8];
        end
        hdr_d = (BYTE_REVERSE != 0) ? hdr_rev : hdr_wire;
    end

    // Control FSM with registered handshake and header outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            cks_q         <= '0;
            pkt_len_q     <= '0;
            len_err_q     <= 1'b0;
            proto_q       <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            macs_q        <= '0;
            macd_q        <= '0;
            id_q          <= '0;
            id_cur_q      <= '0;
            req_ready_q   <= 1'b0;
            hdr_valid_q   <= 1'b0;
            hdr_q         <= '0;
            len_err_out_q <= 1'b0;
            pkt_cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_ready_q && bus.i_req_valid) begin
                        pkt_len_q   <= pkt_len_d;
                        len_err_q   <= ~len_ok;
                        proto_q     <= bus.i_protocol;
                        src_q       <= bus.i_src_ip;
                        dst_q       <= bus.i_dest_ip;
                        macs_q      <= bus.i_mac_src;
                        macd_q      <= bus.i_mac_dest;
                        id_cur_q    <= id_q;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(N_CYC - 1)) begin
                        state_q <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    cks_q   <= cks_d;
                    state_q <= ST_OUT;
                end
                ST_OUT: begin
                    if (!hdr_valid_q) begin
                        hdr_q         <= hdr_d;
                        len_err_out_q <= len_err_q;
                        hdr_valid_q   <= 1'b1;
                    end else if (bus.i_hdr_ready) begin
                        hdr_valid_q <= 1'b0;
                        id_q        <= id_q + 16'd1;
                        pkt_cnt_q   <= pkt_cnt_q + 32'd1;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_hdr_valid = hdr_valid_q;
    assign bus.o_hdr       = hdr_q;
    assign bus.o_len_err   = len_err_out_q;
    assign bus.o_pkt_count = pkt_cnt_q;
endmodule

// File: tb/tb_eth_ip_hdr_gen.sv
// Scoreboard bench for eth_ip_hdr_gen: main instance (2 lanes, wire-order
// output) plus a latency/byte-order sweep over 1, 5 and 10 lanes.
module tb_eth_ip_hdr_gen;
    typedef struct packed {
        logic [15:0] len;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        logic [47:0] macs;
        logic [47:0] macd;
    } req_t;

    localparam logic [159:0] IP_V1 = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;
    localparam logic [159:0] IP_DF = 160'h4500_FFFF_FFFF_4000_40FF_FFFC_FFFF_FFFF_FFFF_3A03;
    localparam logic [47:0]  MACD  = 48'hA1B2_C3D4_E5F6;
    localparam logic [47:0]  MACS  = 48'h0A0B_0C0D_0E0F;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [272:0] sb_q [$];

    always #5 clk = ~clk;

    eth_ip_hdr_gen_if hif ();

    eth_ip_hdr_gen #(.SUM_LANES(2), .BYTE_REVERSE(0), .TTL(64)) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (hif)
    );

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_cks(input logic [159:0] ip);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 10; i++) begin
            s = s + 32'(ip[159-16*i -: 16]);
            if (s > 32'h0000_FFFF) s = s - 32'h0000_FFFF;
        end
        return ~s[15:0];
    endfunction

    // Expected {len_err, header} for TTL 64, wire order
    function automatic logic [272:0] model(input req_t r, input logic [15:0] id);
        logic        err;
        logic [15:0] plen;
        logic [159:0] ip;
        err  = (r.len > 16'd65515);
        plen = err ? 16'hFFFF : r.len + 16'd20;
        ip   = {16'h4500, plen, id, 16'h4000, 8'h40, r.proto, 16'h0000, r.src, r.dst};
        ip[79:64] = ref_cks(ip);
        return {err, r.macd, r.macs, 16'h0800, ip};
    endfunction

    function automatic logic [271:0] rev272(input logic [271:0] h);
        logic [271:0] o;
        for (int i = 0; i < 34; i++) o[8*i +: 8] = h[271-8*i -: 8];
        return o;
    endfunction

    task automatic drive_fields(input req_t r);
        hif.i_payload_len = r.len;
        hif.i_protocol    = r.proto;
        hif.i_src_ip      = r.src;
        hif.i_dest_ip     = r.dst;
        hif.i_mac_src     = r.macs;
        hif.i_mac_dest    = r.macd;
    endtask

    task automatic drive_garbage();
        logic [191:0] g;
        g = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        drive_fields(g[183:0]);
    endtask

    // Issue one request; optionally queue its expectation and check latency
    task automatic send(input req_t r, input bit push, input logic [272:0] exp, input int exp_lat);
        int n;
        int lat;
        @(posedge clk); #1;
        drive_fields(r);
        hif.i_req_valid = 1'b1;
        n = 0;
        while (!hif.o_req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL req_accept_timeout act=%0d exp=<50", n);
        end
        @(posedge clk); #1;
        hif.i_req_valid = 1'b0;
        drive_garbage();
        if (push) sb_q.push_back(exp);
        if (exp_lat > 0) begin
            lat = 0;
            while (!hif.o_hdr_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("latency", 288'(lat), 288'(exp_lat));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout act=%0d exp=0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 288'(hif.o_req_ready), 288'(0));
        chk({tag, "_hdr_valid"}, 288'(hif.o_hdr_valid), 288'(0));
        chk({tag, "_len_err"},   288'(hif.o_len_err),   288'(0));
        chk({tag, "_hdr"},       288'(hif.o_hdr),       288'(0));
        chk({tag, "_pkt_count"}, 288'(hif.o_pkt_count), 288'(0));
    endtask

    // Monitor: pops the scoreboard on each transfer, checks hold stability
    initial begin
        logic [272:0] e;
        logic [271:0] held_hdr;
        logic         held_err;
        bit           held;
        held = 1'b0;
        held_hdr = '0;
        held_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else if (hif.o_hdr_valid) begin
                if (held) begin
                    chk("hold_hdr",     288'(hif.o_hdr),     288'(held_hdr));
                    chk("hold_len_err", 288'(hif.o_len_err), 288'(held_err));
                end
                chk("ready_while_valid", 288'(hif.o_req_ready), 288'(0));
                if (hif.i_hdr_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_hdr act=%0h exp=none", hif.o_hdr);
                    end else begin
                        e = sb_q.pop_front();
                        chk("hdr",     288'(hif.o_hdr),     288'(e[271:0]));
                        chk("len_err", 288'(hif.o_len_err), 288'(e[272]));
                    end
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    held_hdr = hif.o_hdr;
                    held_err = hif.o_len_err;
                end
            end
        end
    end

    // Sweep instances: byte-reversed output, one request each
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int unsigned LN = (g == 0) ? 1 : ((g == 1) ? 5 : 10);
        eth_ip_hdr_gen_if sbus ();
        logic         srst;
        int           lat;
        logic [271:0] cap;
        bit           done;

        eth_ip_hdr_gen #(.SUM_LANES(LN), .BYTE_REVERSE(1), .TTL(64)) u_sw (
            .i_clk   (clk),
            .i_reset (srst),
            .bus     (sbus)
        );

        initial begin
            srst = 1'b1;
            done = 1'b0;
            lat  = 0;
            cap  = '0;
            sbus.i_req_valid   = 1'b0;
            sbus.i_hdr_ready   = 1'b0;
            sbus.i_payload_len = 16'h005F;
            sbus.i_protocol    = 8'h11;
            sbus.i_src_ip      = 32'hC0A8_0001;
            sbus.i_dest_ip     = 32'hC0A8_00C7;
            sbus.i_mac_src     = MACS;
            sbus.i_mac_dest    = MACD;
            repeat (3) @(posedge clk);
            #1 srst = 1'b0;
            @(posedge clk); #1;
            sbus.i_req_valid = 1'b1;
            @(posedge clk); #1;
            sbus.i_req_valid = 1'b0;
            while (!sbus.o_hdr_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            cap = sbus.o_hdr;
            sbus.i_hdr_ready = 1'b1;
            done = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t        v1, v2, vd, vx;
        logic [15:0] exp_id;
        logic [271:0] sw_exp;
        int          n;

        v1 = '{len: 16'h005F, proto: 8'h11, src: 32'hC0A8_0001, dst: 32'hC0A8_00C7,
               macs: MACS, macd: MACD};
        v2 = '{len: 16'h0100, proto: 8'h06, src: 32'h0A00_0001, dst: 32'h0A00_0002,
               macs: 48'h1122_3344_5566, macd: 48'h7788_99AA_BBCC};
        vd = '{len: 16'hFFEB, proto: 8'hFF, src: 32'hFFFF_FFFF, dst: 32'hFFFF_3A03,
               macs: MACS, macd: MACD};

        rst = 1'b1;
        hif.i_req_valid = 1'b0;
        hif.i_hdr_ready = 1'b1;
        drive_fields(v1);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst0");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 288'(hif.o_req_ready), 288'(1));

        // Reference checksum vector, identifier 0
        send(v1, 1'b1, {1'b0, MACD, MACS, 16'h0800, IP_V1}, 7);
        drain();
        chk("pkt_count_1", 288'(hif.o_pkt_count), 288'(1));
        exp_id = 16'd1;

        // Backpressure with stray request valid while busy
        hif.i_hdr_ready = 1'b0;
        send(v2, 1'b1, model(v2, exp_id), 7);
        exp_id = exp_id + 16'd1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                hif.i_req_valid = 1'b1;
                drive_garbage();
            end
            @(posedge clk); #1;
        end
        hif.i_req_valid = 1'b0;
        hif.i_hdr_ready = 1'b1;
        drain();
        chk("pkt_count_bp", 288'(hif.o_pkt_count), 288'(2));

        // Length boundaries
        for (int i = 0; i < 4; i++) begin
            vx = v2;
            case (i)
                0:       vx.len = 16'hFFFF;
                1:       vx.len = 16'h0000;
                2:       vx.len = 16'd65515;
                default: vx.len = 16'd65516;
            endcase
            send(vx, 1'b1, model(vx, exp_id), 7);
            exp_id = exp_id + 16'd1;
            drain();
        end
        chk("pkt_count_len", 288'(hif.o_pkt_count), 288'(6));

        // Identifier wrap with a double-fold checksum
        force u_dut.id_q = 16'hFFFF;
        @(posedge clk); #1;
        release u_dut.id_q;
        send(vd, 1'b1, {1'b0, MACD, MACS, 16'h0800, IP_DF}, 7);
        drain();
        exp_id = 16'h0000;
        send(v2, 1'b1, model(v2, exp_id), 7);
        drain();
        chk("pkt_count_wrap", 288'(hif.o_pkt_count), 288'(8));

        // Reset during SUM aborts the header
        send(v1, 1'b0, '0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("rst_mid");
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("pkt_count_abort", 288'(hif.o_pkt_count), 288'(0));
        send(v1, 1'b1, {1'b0, MACD, MACS, 16'h0800, IP_V1}, 7);
        drain();
        chk("pkt_count_after_abort", 288'(hif.o_pkt_count), 288'(1));

        // Sweep results
        n = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        sw_exp = rev272({MACD, MACS, 16'h0800, IP_V1});
        chk("sweep_lat_l1",  288'(g_sw[0].lat), 288'(12));
        chk("sweep_lat_l5",  288'(g_sw[1].lat), 288'(4));
        chk("sweep_lat_l10", 288'(g_sw[2].lat), 288'(3));
        chk("sweep_hdr_l1",  288'(g_sw[0].cap), 288'(sw_exp));
        chk("sweep_hdr_l5",  288'(g_sw[1].cap), 288'(sw_exp));
        chk("sweep_hdr_l10", 288'(g_sw[2].cap), 288'(sw_exp));
        chk("rev_first_byte", 288'(g_sw[1].cap[7:0]),     288'(8'hA1));
        chk("rev_last_byte",  288'(g_sw[1].cap[271:264]), 288'(8'hC7));
        chk("sb_empty", 288'(sb_q.size()), 288'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
